// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC-select encodings, fetch-state enum, NOP instruction word.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam logic [1:0] PC_HOLD   = 2'b00;
    localparam logic [1:0] PC_INC    = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;
    localparam logic [1:0] PC_BRANCH = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_t;

    localparam logic [15:0] NOP_INSTR = 16'h0000;

endpackage

// File: rtl/pc_next_calc.sv
// Next-PC arithmetic: hold, increment, absolute jump, or sign-extended relative branch.
// Latency: purely combinational.
// Backpressure: none.
module pc_next_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] jump_tgt,
    input  logic [7:0]        disp,
    output logic [ADDR_W-1:0] pc_next
);

    always_comb begin
        pc_next = pc;
        case (pc_sel)
            PC_HOLD:   pc_next = pc;
            PC_INC:    pc_next = pc + ADDR_W'(1);
            PC_JUMP:   pc_next = jump_tgt;
            PC_BRANCH: pc_next = pc + {{(ADDR_W-8){disp[7]}}, disp};
            default:   pc_next = pc;
        endcase
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register plus instruction fetch over a valid-only memory read, latching IR and link PC.
// Latency: fetch_req -> mem_rd next cycle; mem_valid -> instr/instr_valid next cycle (3 cycles zero-wait).
// Backpressure: fetch_busy stalls the controller; memory may stall up to MAX_WAIT cycles before a sticky fault.
module pc_fetch_unit
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_req,
    input  logic              pc_upd,
    input  logic [1:0]        pc_sel,
    input  logic [ADDR_W-1:0] jump_tgt,
    input  logic [7:0]        disp,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] instr,
    output logic              instr_valid,
    output logic              fetch_busy,
    output logic [ADDR_W-1:0] link_pc,
    output logic [ADDR_W-1:0] pc,
    output logic              fetch_fault
);

    fetch_state_t      state, state_nxt;
    logic [7:0]        wait_cnt;
    logic              pend_fetch, pend_fetch_nxt;
    logic              pend_vld, pend_vld_nxt;
    logic [1:0]        pend_sel;
    logic [ADDR_W-1:0] pend_tgt;
    logic [7:0]        pend_disp;
    logic              cap_pend;
    logic              take_instr;
    logic [ADDR_W-1:0] pc_nxt, live_pc, pend_pc;

    pc_next_calc #(.ADDR_W(ADDR_W)) u_live_calc (
        .pc       (pc),
        .pc_sel   (pc_sel),
        .jump_tgt (jump_tgt),
        .disp     (disp),
        .pc_next  (live_pc)
    );

    pc_next_calc #(.ADDR_W(ADDR_W)) u_pend_calc (
        .pc       (pc),
        .pc_sel   (pend_sel),
        .jump_tgt (pend_tgt),
        .disp     (pend_disp),
        .pc_next  (pend_pc)
    );

    always_comb begin
        state_nxt      = state;
        pend_fetch_nxt = pend_fetch;
        pend_vld_nxt   = pend_vld;
        pc_nxt         = pc;
        cap_pend       = 1'b0;
        take_instr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (pc_upd) begin
                    pc_nxt       = live_pc;
                    pend_vld_nxt = 1'b0;
                end else if (pend_vld) begin
                    pc_nxt       = pend_pc;
                    pend_vld_nxt = 1'b0;
                end
                // A PC change this cycle defers the fetch by one cycle so REQ sees the new PC.
                if (fetch_req || pend_fetch) begin
                    if (pc_upd || pend_vld) begin
                        pend_fetch_nxt = 1'b1;
                    end else begin
                        pend_fetch_nxt = 1'b0;
                        state_nxt      = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                cap_pend  = pc_upd;
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                cap_pend = pc_upd;
                if (mem_valid) begin
                    take_instr = 1'b1;
                    state_nxt  = ST_IDLE;
                end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                    state_nxt = ST_FAULT;
                end
            end
            ST_FAULT: state_nxt = ST_FAULT;
            default:  state_nxt = ST_IDLE;
        endcase
        if (cap_pend) begin
            pend_vld_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            instr       <= DATA_W'(NOP_INSTR);
            link_pc     <= RESET_PC + ADDR_W'(1);
            instr_valid <= 1'b0;
            wait_cnt    <= 8'd0;
            pend_fetch  <= 1'b0;
            pend_vld    <= 1'b0;
            pend_sel    <= PC_HOLD;
            pend_tgt    <= '0;
            pend_disp   <= 8'd0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            pend_fetch  <= pend_fetch_nxt;
            pend_vld    <= pend_vld_nxt;
            instr_valid <= take_instr;
            wait_cnt    <= (state == ST_WAIT) ? wait_cnt + 8'd1 : 8'd0;
            if (cap_pend) begin
                pend_sel  <= pc_sel;
                pend_tgt  <= jump_tgt;
                pend_disp <= disp;
            end
            if (take_instr) begin
                instr   <= mem_rdata;
                link_pc <= pc + ADDR_W'(1);
            end else if (state_nxt == ST_FAULT) begin
                instr <= DATA_W'(NOP_INSTR);
            end
        end
    end

    assign mem_rd      = (state == ST_REQ) || (state == ST_WAIT);
    assign mem_addr    = pc;
    assign fetch_busy  = (state != ST_IDLE) || pend_fetch;
    assign fetch_fault = (state == ST_FAULT);

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a transaction-level model of the fetch stage.
module tb_pc_fetch_unit;

    localparam int MAX_WAIT = 15;
    localparam int M_IDLE = 0, M_ISSUE = 1, M_WAIT = 2, M_DEAD = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req, pc_upd, mem_valid;
    logic [1:0]  pc_sel;
    logic [15:0] jump_tgt, mem_rdata;
    logic [7:0]  disp;
    logic        mem_rd, instr_valid, fetch_busy, fetch_fault;
    logic [15:0] mem_addr, instr, link_pc, pc;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 1'b0;

    pc_fetch_unit #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_upd(pc_upd), .pc_sel(pc_sel),
        .jump_tgt(jump_tgt), .disp(disp), .mem_rd(mem_rd), .mem_addr(mem_addr),
        .mem_valid(mem_valid), .mem_rdata(mem_rdata), .instr(instr), .instr_valid(instr_valid),
        .fetch_busy(fetch_busy), .link_pc(link_pc), .pc(pc), .fetch_fault(fetch_fault)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [1:0]  sel;
        logic [15:0] tgt;
        logic [7:0]  d;
    } upd_t;

    int          m_mode;
    int          m_waited;
    logic [15:0] m_pc, m_instr, m_link;
    bit          m_iv, m_fetch_pend;
    upd_t        m_pq[$];

    function automatic logic [15:0] next_pc(input logic [15:0] p, input logic [1:0] s,
                                            input logic [15:0] t, input logic [7:0] d);
        int r;
        case (s)
            2'd1:    r = int'(p) + 1;
            2'd2:    r = int'(t);
            2'd3:    r = int'(p) + int'($signed(d));
            default: r = int'(p);
        endcase
        return 16'(r & 32'hFFFF);
    endfunction

    task automatic m_reset();
        m_mode = M_IDLE; m_waited = 0;
        m_pc = 16'h0000; m_instr = 16'h0000; m_link = 16'h0001;
        m_iv = 1'b0; m_fetch_pend = 1'b0;
        m_pq.delete();
    endtask

    task automatic m_step();
        upd_t u;
        bit   changed;
        changed = 1'b0;
        m_iv = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (pc_upd) begin
                    m_pc = next_pc(m_pc, pc_sel, jump_tgt, disp);
                    m_pq.delete();
                    changed = 1'b1;
                end else if (m_pq.size() > 0) begin
                    u = m_pq.pop_front();
                    m_pc = next_pc(m_pc, u.sel, u.tgt, u.d);
                    changed = 1'b1;
                end
                if (fetch_req || m_fetch_pend) begin
                    if (changed) m_fetch_pend = 1'b1;
                    else begin m_fetch_pend = 1'b0; m_mode = M_ISSUE; end
                end
            end
            M_ISSUE, M_WAIT: begin
                if (pc_upd) begin
                    m_pq.delete();
                    m_pq.push_back(upd_t'{pc_sel, jump_tgt, disp});
                end
                if (m_mode == M_ISSUE) begin
                    m_mode = M_WAIT; m_waited = 0;
                end else if (mem_valid) begin
                    m_instr = mem_rdata; m_link = m_pc + 16'd1; m_iv = 1'b1; m_mode = M_IDLE;
                end else begin
                    m_waited++;
                    if (m_waited == MAX_WAIT) begin m_mode = M_DEAD; m_instr = 16'h0000; end
                end
            end
            default: ;
        endcase
    endtask

    always @(posedge clk) if (reset) m_step();

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) if (cmp_en) begin
        chk("mem_rd",      32'(mem_rd),      32'(m_mode == M_ISSUE || m_mode == M_WAIT));
        chk("mem_addr",    32'(mem_addr),    32'(m_pc));
        chk("pc",          32'(pc),          32'(m_pc));
        chk("instr",       32'(instr),       32'(m_instr));
        chk("instr_valid", 32'(instr_valid), 32'(m_iv));
        chk("link_pc",     32'(link_pc),     32'(m_link));
        chk("fetch_busy",  32'(fetch_busy),  32'(m_mode != M_IDLE || m_fetch_pend));
        chk("fetch_fault", 32'(fetch_fault), 32'(m_mode == M_DEAD));
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic clear_in();
        fetch_req = 1'b0; pc_upd = 1'b0; pc_sel = 2'd0; jump_tgt = 16'h0; disp = 8'h0;
        mem_valid = 1'b0; mem_rdata = 16'h0;
    endtask

    task automatic rst_pulse();
        #2 reset = 1'b0;
        m_reset();
        #1 chk("rst_mem_rd_now", 32'(mem_rd), 32'd0);
        @(negedge clk);
        #2 reset = 1'b1;
    endtask

    task automatic do_upd(input logic [1:0] s, input logic [15:0] t, input logic [7:0] d);
        pc_upd = 1'b1; pc_sel = s; jump_tgt = t; disp = d;
        tick();
        pc_upd = 1'b0;
    endtask

    initial begin
        clear_in();
        reset = 1'b0;
        m_reset();
        cmp_en = 1'b1;
        @(negedge clk);
        #2 reset = 1'b1;
        tick();
        chk("rst_pc", 32'(pc), 32'h0000);
        chk("rst_link", 32'(link_pc), 32'h0001);
        chk("rst_busy", 32'(fetch_busy), 32'd0);

        // 1: zero-wait fetch, valid already high during REQ and first WAIT
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0; mem_valid = 1'b1; mem_rdata = 16'h5321;
        chk("t1_mem_rd", 32'(mem_rd), 32'd1);
        chk("t1_addr", 32'(mem_addr), 32'h0000);
        tick();
        tick();
        mem_valid = 1'b0;
        chk("t1_instr", 32'(instr), 32'h5321);
        chk("t1_link", 32'(link_pc), 32'h0001);
        chk("t1_ivalid", 32'(instr_valid), 32'd1);
        tick();
        chk("t1_ivalid_pulse", 32'(instr_valid), 32'd0);

        // 2: branch arithmetic and wrap
        do_upd(2'b10, 16'h00FE, 8'h00);
        chk("t2_jump", 32'(pc), 32'h00FE);
        do_upd(2'b11, 16'h0000, 8'hFC);
        chk("t2_br_neg", 32'(pc), 32'h00FA);
        do_upd(2'b11, 16'h0000, 8'h05);
        chk("t2_br_pos", 32'(pc), 32'h00FF);
        do_upd(2'b10, 16'hFFFF, 8'h00);
        do_upd(2'b01, 16'h0000, 8'h00);
        chk("t2_wrap", 32'(pc), 32'h0000);

        // 3: delayed valid with a mid-WAIT jump held back until IDLE
        do_upd(2'b10, 16'h0100, 8'h00);
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("t3_mem_rd", 32'(mem_rd), 32'd1);
            chk("t3_addr", 32'(mem_addr), 32'h0100);
            chk("t3_busy", 32'(fetch_busy), 32'd1);
            pc_upd = (i == 1); pc_sel = 2'b10; jump_tgt = 16'h1234;
            tick();
        end
        pc_upd = 1'b0;
        mem_valid = 1'b1; mem_rdata = 16'hABCD;
        chk("t3_pc_held", 32'(pc), 32'h0100);
        tick();
        mem_valid = 1'b0;
        chk("t3_instr", 32'(instr), 32'hABCD);
        chk("t3_pc_first_idle", 32'(pc), 32'h0100);
        tick();
        chk("t3_pc_applied", 32'(pc), 32'h1234);

        // 4: timeout -> sticky fault
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        repeat (MAX_WAIT - 1) tick();
        chk("t4_not_yet", 32'(fetch_fault), 32'd0);
        tick();
        chk("t4_fault", 32'(fetch_fault), 32'd1);
        chk("t4_mem_rd", 32'(mem_rd), 32'd0);
        chk("t4_instr", 32'(instr), 32'h0000);
        fetch_req = 1'b1; pc_upd = 1'b1; pc_sel = 2'b01;
        repeat (3) tick();
        clear_in();
        chk("t4_pc_frozen", 32'(pc), 32'h1234);
        chk("t4_still_fault", 32'(fetch_fault), 32'd1);
        rst_pulse();
        tick();
        chk("t4_reset_clears", 32'(fetch_fault), 32'd0);

        // 5: jump and fetch together
        pc_upd = 1'b1; pc_sel = 2'b10; jump_tgt = 16'h0040; fetch_req = 1'b1;
        tick();
        clear_in();
        chk("t5_pc", 32'(pc), 32'h0040);
        chk("t5_busy", 32'(fetch_busy), 32'd1);
        tick();
        chk("t5_req", 32'(mem_rd), 32'd1);
        chk("t5_addr", 32'(mem_addr), 32'h0040);
        mem_valid = 1'b1; mem_rdata = 16'h1111;
        tick();
        tick();
        mem_valid = 1'b0;
        chk("t5_link", 32'(link_pc), 32'h0041);

        // 6: reset in the middle of WAIT
        fetch_req = 1'b1;
        tick();
        fetch_req = 1'b0;
        tick();
        chk("t6_in_wait", 32'(mem_rd), 32'd1);
        rst_pulse();
        tick();
        chk("t6_pc", 32'(pc), 32'h0000);
        chk("t6_idle", 32'(fetch_busy), 32'd0);
        chk("t6_fault", 32'(fetch_fault), 32'd0);

        // randomized traffic; a live update never collides with a pending-slot apply
        for (int c = 0; c < 3000; c++) begin
            fetch_req = ($urandom_range(0, 2) == 0);
            pc_upd    = ($urandom_range(0, 5) == 0) && !(m_mode == M_IDLE && m_pq.size() != 0);
            pc_sel    = 2'($urandom);
            jump_tgt  = 16'($urandom);
            disp      = 8'($urandom);
            mem_valid = ($urandom_range(0, 4) < 2);
            mem_rdata = 16'($urandom);
            if ($urandom_range(0, 399) == 0) rst_pulse();
            else tick();
        end
        clear_in();
        tick();
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
